// File: rtl/draw_rect_engine_pkg.sv
// Shared defaults, FSM encoding and a clamp helper for the rectangle fill engine.
package draw_rect_engine_pkg;

    localparam int DRE_SPX_W   = 6;
    localparam int DRE_SPY_W   = 6;
    localparam int DRE_SP_SIZE = 10;
    localparam int DRE_PIX_X_W = 10;
    localparam int DRE_PIX_Y_W = 9;
    localparam int DRE_H_RES   = 640;
    localparam int DRE_V_RES   = 480;
    localparam int DRE_ADDR_W  = 19;
    localparam int DRE_COLOR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] clamp_max(input logic [31:0] a, input logic [31:0] lim);
        return (a > lim) ? lim : a;
    endfunction

endpackage

// File: rtl/draw_rect_engine_pixel_addr_gen.sv
// Linear frame-buffer address for a pixel: y*H_RES + x.
module pixel_addr_gen
    import draw_rect_engine_pkg::*;
#(
    parameter int H_RES   = DRE_H_RES,
    parameter int PIX_X_W = DRE_PIX_X_W,
    parameter int PIX_Y_W = DRE_PIX_Y_W,
    parameter int ADDR_W  = DRE_ADDR_W
) (
    input  logic [PIX_X_W-1:0] i_x,
    input  logic [PIX_Y_W-1:0] i_y,
    output logic [ADDR_W-1:0]  o_addr
);

    always_comb begin
        o_addr = ADDR_W'(i_y) * ADDR_W'(H_RES) + ADDR_W'(i_x);
    end

endmodule

// File: rtl/draw_rect_engine.sv
// Rasterises a superpixel-aligned rectangle (solid or outline) into the VGA RAM,
// one pixel per cycle, with RAM backpressure.
module draw_rect_engine
    import draw_rect_engine_pkg::*;
#(
    parameter int SPX_W   = DRE_SPX_W,
    parameter int SPY_W   = DRE_SPY_W,
    parameter int SP_SIZE = DRE_SP_SIZE,
    parameter int PIX_X_W = DRE_PIX_X_W,
    parameter int PIX_Y_W = DRE_PIX_Y_W,
    parameter int H_RES   = DRE_H_RES,
    parameter int V_RES   = DRE_V_RES,
    parameter int ADDR_W  = DRE_ADDR_W,
    parameter int COLOR_W = DRE_COLOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SPX_W-1:0]   x,
    input  logic [SPY_W-1:0]   y,
    input  logic [SPX_W-1:0]   w,
    input  logic [SPY_W-1:0]   h,
    input  logic [COLOR_W-1:0] idata,
    input  logic               imode,
    input  logic               ivalid,
    output logic               iready,
    input  logic               istall,
    output logic               obusy,
    output logic               odone,
    output logic [ADDR_W-1:0]  oaddr,
    output logic [COLOR_W-1:0] odata,
    output logic               owren
);

    state_t r_state, w_next;

    logic [SPX_W-1:0]   r_x, r_w;
    logic [SPY_W-1:0]   r_y, r_h;
    logic [COLOR_W-1:0] r_color;
    logic               r_mode;
    logic [PIX_X_W-1:0] r_tlx, r_brx, r_px;
    logic [PIX_Y_W-1:0] r_tly, r_bry, r_py;
    logic [31:0]        r_bx_lo, r_bx_hi, r_by_lo, r_by_hi;

    logic [31:0]        w_tlx, w_tly, w_brx_raw, w_bry_raw, w_bx_hi, w_by_hi;
    logic [PIX_X_W-1:0] w_brx;
    logic [PIX_Y_W-1:0] w_bry;
    logic               w_empty, w_in_draw, w_take, w_last, w_border;
    logic [ADDR_W-1:0]  w_addr;

    // 32-bit intermediates so (x+w)*SP_SIZE never wraps before clipping.
    assign w_tlx     = 32'(r_x) * 32'(SP_SIZE);
    assign w_tly     = 32'(r_y) * 32'(SP_SIZE);
    assign w_brx_raw = clamp_max((32'(r_x) + 32'(r_w)) * 32'(SP_SIZE) - 32'd1, 32'(H_RES - 1));
    assign w_bry_raw = clamp_max((32'(r_y) + 32'(r_h)) * 32'(SP_SIZE) - 32'd1, 32'(V_RES - 1));
    assign w_brx     = w_brx_raw[PIX_X_W-1:0];
    assign w_bry     = w_bry_raw[PIX_Y_W-1:0];
    assign w_bx_hi   = (32'(r_x) + 32'(r_w) - 32'd1) * 32'(SP_SIZE);
    assign w_by_hi   = (32'(r_y) + 32'(r_h) - 32'd1) * 32'(SP_SIZE);
    assign w_empty   = (r_w == '0) || (r_h == '0) ||
                       (w_tlx >= 32'(H_RES)) || (w_tly >= 32'(V_RES));

    assign w_in_draw = (r_state == ST_DRAW);
    assign w_take    = w_in_draw && !istall;
    assign w_last    = (r_px == r_brx) && (r_py == r_bry);
    // Border thresholds come from the unclipped rectangle, so a clipped side gets no border.
    assign w_border  = (32'(r_px) < r_bx_lo) || (32'(r_px) >= r_bx_hi) ||
                       (32'(r_py) < r_by_lo) || (32'(r_py) >= r_by_hi);

    pixel_addr_gen #(
        .H_RES  (H_RES),
        .PIX_X_W(PIX_X_W),
        .PIX_Y_W(PIX_Y_W),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .i_x   (r_px),
        .i_y   (r_py),
        .o_addr(w_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (ivalid) w_next = ST_SETUP;
            ST_SETUP: w_next = w_empty ? ST_DONE : ST_DRAW;
            ST_DRAW:  if (w_take && w_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        iready = (r_state == ST_IDLE);
        obusy  = (r_state != ST_IDLE);
        odone  = (r_state == ST_DONE);
        owren  = w_in_draw && (!r_mode || w_border);
        oaddr  = owren ? w_addr : '0;
        odata  = owren ? r_color : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0; r_y <= '0; r_w <= '0; r_h <= '0;
            r_color <= '0; r_mode <= 1'b0;
            r_tlx <= '0; r_brx <= '0; r_px <= '0;
            r_tly <= '0; r_bry <= '0; r_py <= '0;
            r_bx_lo <= '0; r_bx_hi <= '0; r_by_lo <= '0; r_by_hi <= '0;
        end else begin
            if (r_state == ST_IDLE && ivalid) begin
                r_x <= x; r_y <= y; r_w <= w; r_h <= h;
                r_color <= idata; r_mode <= imode;
            end
            if (r_state == ST_SETUP) begin
                r_tlx   <= w_tlx[PIX_X_W-1:0];
                r_tly   <= w_tly[PIX_Y_W-1:0];
                r_brx   <= w_brx;
                r_bry   <= w_bry;
                r_px    <= w_tlx[PIX_X_W-1:0];
                r_py    <= w_tly[PIX_Y_W-1:0];
                r_bx_lo <= w_tlx + 32'(SP_SIZE);
                r_by_lo <= w_tly + 32'(SP_SIZE);
                r_bx_hi <= w_bx_hi;
                r_by_hi <= w_by_hi;
            end
            if (w_take) begin
                if (r_px == r_brx) begin
                    r_px <= r_tlx;
                    if (r_py != r_bry) r_py <= r_py + 1'b1;
                end else begin
                    r_px <= r_px + 1'b1;
                end
            end
        end
    end

endmodule
